// File: rtl/qp_wb_pkg.sv
// Shared types and constants for the query-patch Wishbone loader.
package qp_wb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StBeat,
      StDone
   } state_e;

   // One patch is streamed as eight byte-lane beats of a 64-bit word.
   localparam int unsigned BEATS_PER_PATCH = 8;
   // Bit position of the beat index inside the write data.
   localparam int unsigned LANE_SEL_LSB    = 11;
   localparam int unsigned LANE_WIDTH      = 8;

endpackage

// File: rtl/query_patch_wb_loader_if.sv
// Wishbone master write bus carrying patch beats to the patch RAM.
interface query_patch_wb_loader_if;

   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] dat;
   logic        ack;

   modport master (
      output cyc, stb, we, sel, adr, dat,
      input  ack
   );

   modport slave (
      input  cyc, stb, we, sel, adr, dat,
      output ack
   );

endinterface

// File: rtl/query_patch_wb_loader.sv
// Accepts a packed patch, then writes it to patch RAM as eight Wishbone beats,
// one byte lane per beat, aborting a beat that waits too long for ack.
module query_patch_wb_loader
   import qp_wb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH        = 11,
   parameter int unsigned PATCH_SIZE        = 5,
   parameter int unsigned ADDR_WIDTH        = 9,
   parameter int unsigned WB_ADDRESS_OFFSET = 557,
   parameter int unsigned ACK_TIMEOUT       = 255
) (
   input  logic                           wb_clk_i,
   input  logic                           wb_rst_i,
   input  logic                           patch_valid_i,
   output logic                           patch_ready_o,
   input  logic [DATA_WIDTH*PATCH_SIZE-1:0] patch_i,
   input  logic [ADDR_WIDTH-1:0]          patch_addr_i,
   query_patch_wb_loader_if.master        wbm,
   input  logic                           clear_err_i,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           timeout_o,
   output logic [ADDR_WIDTH:0]            patch_count_o
);

   localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);
   // Last stall count before the beat is abandoned.
   localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);
   localparam logic [2:0]      BeatLast = 3'(BEATS_PER_PATCH - 1);

   state_e                state_q, state_d;
   logic [2:0]            k_q, k_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [63:0]           word_q, word_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  timeout_q, timeout_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;

   // State and datapath registers; reset abandons any partial row.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= StIdle;
         k_q       <= '0;
         cnt_q     <= '0;
         word_q    <= '0;
         addr_q    <= '0;
         timeout_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         cnt_q     <= cnt_d;
         word_q    <= word_d;
         addr_q    <= addr_d;
         timeout_q <= timeout_d;
         count_q   <= count_d;
      end
   end

   // Next-state: capture, beat sequencing, stall timeout and completion.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      cnt_d     = cnt_q;
      word_d    = word_q;
      addr_d    = addr_q;
      timeout_d = timeout_q;
      count_d   = count_q;

      if (clear_err_i) timeout_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (patch_valid_i && !timeout_q) begin
               word_d  = 64'(patch_i);
               addr_d  = patch_addr_i;
               k_d     = '0;
               cnt_d   = '0;
               state_d = StBeat;
            end
         end
         StBeat: begin
            // ack wins over a timeout that would fire in the same cycle
            if (wbm.ack) begin
               cnt_d = '0;
               if (k_q == BeatLast) state_d = StDone;
               else                 k_d     = k_q + 3'd1;
            end else if (cnt_q == CntLast) begin
               // Set after the clear so a simultaneous clear loses
               timeout_d = 1'b1;
               cnt_d     = '0;
               k_d       = '0;
               state_d   = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            count_d = count_q + 1'b1;
            k_d     = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Bus and status outputs decoded from the current state.
   always_comb begin
      wbm.cyc = 1'b0;
      wbm.stb = 1'b0;
      wbm.we  = 1'b0;
      wbm.sel = 4'h0;
      wbm.adr = '0;
      wbm.dat = '0;
      if (state_q == StBeat) begin
         wbm.cyc = 1'b1;
         wbm.stb = 1'b1;
         wbm.we  = 1'b1;
         wbm.sel = 4'hF;
         wbm.adr = WB_ADDRESS_OFFSET + 32'(addr_q);
         wbm.dat[LANE_SEL_LSB +: 3]   = k_q;
         wbm.dat[LANE_WIDTH-1:0]      = word_q[{k_q, 3'b000} +: LANE_WIDTH];
      end
   end

   assign patch_ready_o = (state_q == StIdle) && !timeout_q;
   assign busy_o        = (state_q != StIdle);
   assign done_o        = (state_q == StDone);
   assign timeout_o     = timeout_q;
   assign patch_count_o = count_q;

endmodule

// File: tb/tb_query_patch_wb_loader.sv
// Directed bench for the query-patch Wishbone loader.
module tb_query_patch_wb_loader;

   logic          clk = 1'b0;
   logic          rst;
   logic          patch_valid;
   logic          patch_ready;
   logic [54:0]   patch;
   logic [8:0]    patch_addr;
   logic          clear_err;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [9:0]    count;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [54:0] P = 55'h12_3456_789A_BCDE;
   // Expected write data per beat: {k, 3'b0, byte k} with k at bit 11
   logic [31:0] exp_dat [8] = '{32'h0000_00DE, 32'h0000_08BC, 32'h0000_109A, 32'h0000_1878,
                                32'h0000_2056, 32'h0000_2834, 32'h0000_3012, 32'h0000_3800};

   query_patch_wb_loader_if wbm_if ();

   query_patch_wb_loader #(
      .DATA_WIDTH        (11),
      .PATCH_SIZE        (5),
      .ADDR_WIDTH        (9),
      .WB_ADDRESS_OFFSET (557),
      .ACK_TIMEOUT       (4)
   ) dut (
      .wb_clk_i      (clk),
      .wb_rst_i      (rst),
      .patch_valid_i (patch_valid),
      .patch_ready_o (patch_ready),
      .patch_i       (patch),
      .patch_addr_i  (patch_addr),
      .wbm           (wbm_if.master),
      .clear_err_i   (clear_err),
      .busy_o        (busy),
      .done_o        (done),
      .timeout_o     (timeout),
      .patch_count_o (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer a patch at the current negedge; returns in the first beat cycle.
   task automatic offer(input logic [8:0] a);
      patch_valid = 1'b1;
      patch       = P;
      patch_addr  = a;
      chk("ready_before_accept", 64'(patch_ready), 64'd1);
      @(negedge clk);
      patch_valid = 1'b0;
      patch       = ~P;
      patch_addr  = ~a;
   endtask

   // Eight beats with ack held high; returns in the done cycle.
   task automatic beats_fast(input logic [31:0] adr);
      for (int k = 0; k < 8; k++) begin
         chk("beat_cyc", 64'(wbm_if.cyc), 64'd1);
         chk("beat_stb_we_sel", 64'({wbm_if.stb, wbm_if.we, wbm_if.sel}), 64'h3F);
         chk("beat_adr", 64'(wbm_if.adr), 64'(adr));
         chk("beat_dat", 64'(wbm_if.dat), 64'(exp_dat[k]));
         chk("beat_no_done", 64'(done), 64'd0);
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1; patch_valid = 1'b0; patch = '0; patch_addr = '0;
      clear_err = 1'b0; wbm_if.ack = 1'b0;
      #2;
      chk("rst_ready", 64'(patch_ready), 64'd1);
      chk("rst_busy_done_to", 64'({busy, done, timeout}), 64'd0);
      chk("rst_bus", 64'({wbm_if.cyc, wbm_if.stb, wbm_if.we, wbm_if.sel}), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Full-rate transfer to row 3
      wbm_if.ack = 1'b1;
      offer(9'd3);
      beats_fast(32'd560);
      chk("fast_done", 64'(done), 64'd1);
      chk("fast_done_bus", 64'({wbm_if.cyc, wbm_if.stb}), 64'd0);
      chk("fast_done_ready", 64'(patch_ready), 64'd0);
      @(negedge clk);
      chk("fast_idle_ready", 64'(patch_ready), 64'd1);
      chk("fast_done_pulse", 64'(done), 64'd0);
      chk("fast_count", 64'(count), 64'd1);

      // ack after three stall cycles per beat; last stall hits the timeout boundary
      wbm_if.ack = 1'b0;
      offer(9'd3);
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 4; j++) begin
            chk("slow_cyc", 64'(wbm_if.cyc), 64'd1);
            chk("slow_adr", 64'(wbm_if.adr), 64'd560);
            chk("slow_dat", 64'(wbm_if.dat), 64'(exp_dat[k]));
            wbm_if.ack = (j == 3);
            @(negedge clk);
         end
         wbm_if.ack = 1'b0;
      end
      chk("slow_done", 64'(done), 64'd1);
      chk("slow_timeout", 64'(timeout), 64'd0);
      @(negedge clk);
      chk("slow_count", 64'(count), 64'd2);

      // No ack: beat 0 aborted after four stall cycles
      offer(9'd7);
      for (int i = 0; i < 4; i++) begin
         chk("to_stall_cyc", 64'(wbm_if.cyc), 64'd1);
         @(negedge clk);
      end
      chk("to_bus_drop", 64'({wbm_if.cyc, wbm_if.stb}), 64'd0);
      chk("to_flag", 64'(timeout), 64'd1);
      chk("to_ready", 64'(patch_ready), 64'd0);
      chk("to_busy_done", 64'({busy, done}), 64'd0);
      patch_valid = 1'b1;
      @(negedge clk);
      chk("to_valid_ignored", 64'(busy), 64'd0);
      patch_valid = 1'b0;
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      chk("to_cleared", 64'(timeout), 64'd0);
      chk("to_ready_again", 64'(patch_ready), 64'd1);
      chk("to_count", 64'(count), 64'd2);

      // Clear in the same cycle the timeout fires
      offer(9'd7);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) clear_err = 1'b1;
         @(negedge clk);
      end
      clear_err = 1'b0;
      chk("clr_same_cycle", 64'(timeout), 64'd1);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      chk("clr_after", 64'(timeout), 64'd0);

      // Reset during beat 4
      wbm_if.ack = 1'b1;
      offer(9'd3);
      for (int k = 0; k < 4; k++) @(negedge clk);
      chk("mid_beat4_dat", 64'(wbm_if.dat), 64'(exp_dat[4]));
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_bus", 64'({wbm_if.cyc, wbm_if.stb}), 64'd0);
      chk("mid_rst_ready", 64'(patch_ready), 64'd1);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_count", 64'(count), 64'd0);
      offer(9'd3);
      beats_fast(32'd560);
      chk("mid_restart_done", 64'(done), 64'd1);

      // Back-to-back patches to rows 0 and 511 from a clean reset
      @(negedge clk);
      rst = 1'b1;
      #1 rst = 1'b0;
      @(negedge clk);
      patch_valid = 1'b1; patch = P; patch_addr = 9'd0;
      @(negedge clk);
      patch_addr = 9'd511;
      beats_fast(32'd557);
      chk("b2b_done1", 64'(done), 64'd1);
      chk("b2b_not_ready_done", 64'(patch_ready), 64'd0);
      @(negedge clk);
      chk("b2b_ready_t10", 64'(patch_ready), 64'd1);
      @(negedge clk);
      patch_valid = 1'b0;
      beats_fast(32'd1068);
      chk("b2b_done2", 64'(done), 64'd1);
      @(negedge clk);
      chk("b2b_count", 64'(count), 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/query_patch_wb_loader.md
QUERY_PATCH_WB_LOADER -- requirements
Module: query_patch_wb_loader

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 11, patch element width; PATCH_SIZE, 5, elements per patch; ADDR_WIDTH, 9, patch RAM address width; WB_ADDRESS_OFFSET, 557, Wishbone base of patch RAM; ACK_TIMEOUT, 255, max cycles waiting per beat.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 wb_clk_i  in  1  clock.
REQ-004 wb_rst_i  in  1  asynchronous active-high reset.
REQ-005 patch_valid_i  in  1  patch offered.
REQ-006 patch_ready_o  out  1  loader can accept a patch.
REQ-007 patch_i  in  DATA_WIDTH*PATCH_SIZE  packed patch.
REQ-008 patch_addr_i  in  ADDR_WIDTH  target RAM row.
REQ-009 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master cycle/strobe/write.
REQ-010 wbm_sel_o  out  4  byte select.
REQ-011 wbm_adr_o, wbm_dat_o  out  32 each  Wishbone address/write data.
REQ-012 wbm_ack_i  in  1  Wishbone acknowledge.
REQ-013 clear_err_i  in  1  clears timeout_o.
REQ-014 busy_o  out  1  transfer in progress; done_o  out  1  one-cycle completion pulse; timeout_o  out  1  sticky abort flag.
REQ-015 patch_count_o  out  ADDR_WIDTH+1  completed patches since reset, wraps at 2^(ADDR_WIDTH+1).

Function
REQ-016 States SHALL be IDLE, BEAT, DONE.
REQ-017 patch_ready_o SHALL be 1 only in IDLE with timeout_o=0.
REQ-018 On patch_valid_i&patch_ready_o at an edge, SHALL capture patch_i zero-extended to 64 bits and patch_addr_i, clear beat index k=0, enter BEAT.
REQ-019 In BEAT: cyc=stb=we=1, sel=4'hF, adr=WB_ADDRESS_OFFSET+captured addr (32-bit, zero-extended), dat={18'b0, k[2:0], 3'b0, byte k of captured word}.
REQ-020 cyc SHALL stay high across all 8 beats; stb SHALL stay high continuously; ack SHALL be honoured only while stb=1.
REQ-021 ack with k<7 SHALL increment k, reset timeout counter; ack with k=7 SHALL enter DONE.
REQ-022 With ack asserted every cycle: accept at edge T, beats occupy cycles T+1..T+8, done_o=1 and cyc=stb=0 in cycle T+9, IDLE (ready=1) at T+10.
REQ-023 DONE SHALL last one cycle, pulse done_o, increment patch_count_o, return to IDLE.
REQ-024 Per-beat counter SHALL count cycles without ack; reaching ACK_TIMEOUT SHALL drop cyc/stb next cycle, set timeout_o, return to IDLE without done_o or count increment.
REQ-025 ack in the same cycle the counter reaches ACK_TIMEOUT SHALL be treated as ack (no timeout).
REQ-026 clear_err_i SHALL clear timeout_o next edge; if clear and timeout fire same cycle, timeout_o SHALL become 1.
REQ-027 busy_o SHALL equal (state!=IDLE); all Wishbone outputs SHALL be 0 in IDLE.
REQ-028 patch_valid_i while not ready SHALL be ignored; patch_i changes after capture SHALL not affect beats.

Reset
REQ-029 wb_rst_i SHALL immediately force IDLE, k=0, counter=0, all outputs 0 except patch_ready_o=1, including mid-transfer (cyc/stb drop asynchronously, partial row left unfinished).

Structure
REQ-030 State enum, BEATS_PER_PATCH=8, LANE_SEL_LSB=11, LANE_WIDTH=8 SHALL live in package qp_wb_pkg.
REQ-031 Single module, no sub-module; timeout counter width $clog2(ACK_TIMEOUT+1).

Verification
REQ-032 patch_i=55'h12_3456_789A_BCDE, addr=3, ack every cycle -> 8 writes adr=560, dat[13:11]=0..7, dat[7:0]=DE,BC,9A,78,56,34,12,00; done_o at T+9; count=1.
REQ-033 Same patch, ack delayed 3 cycles per beat -> each beat holds adr/dat stable until ack; done_o at T+33.
REQ-034 No ack, ACK_TIMEOUT=4 -> cyc/stb drop after 4 stall cycles of beat 0, timeout_o=1, ready=0 until clear_err_i, count unchanged.
REQ-035 wb_rst_i asserted during beat 4 -> cyc/stb=0 same cycle, ready=1 after release, next patch starts at k=0.
REQ-036 Two back-to-back valid patches (addr 0, 511) -> second accepted at T+10, adr=557 then 1068, count=2.
REQ-037 Timeout and clear_err_i same cycle -> timeout_o=1.
